// File: rtl/pdh_pkg.sv
// Shared PDH definitions used by the DAC ramp sequencer.
//   DAC_DATA_WIDTH : DAC code width
//   DAC_MIDSCALE   : code for ~0 V output, also the reset code
//   ramp_state_t   : sweep FSM states
package pdh_pkg;

  localparam int DAC_DATA_WIDTH = 14;
  localparam logic [DAC_DATA_WIDTH-1:0] DAC_MIDSCALE = 14'h2000;

  typedef enum logic [1:0] {
    RAMP_IDLE = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2,
    RAMP_PARK = 2'd3
  } ramp_state_t;

endpackage

// File: rtl/dac_ramp_sequencer_if.sv
// Shared DAC write port bundle.
//   man_req_i/man_dat_i/man_sel_i : single-shot manual write from the PS decoder
//   dac_dat_o/dac_sel_o/dac_wrt_o : registered DAC pin drive
// master = command side / pin consumer, slave = sequencer.
interface dac_ramp_sequencer_if #(
  parameter int W = 14
);
  logic         man_req_i;
  logic [W-1:0] man_dat_i;
  logic         man_sel_i;
  logic [W-1:0] dac_dat_o;
  logic         dac_sel_o;
  logic         dac_wrt_o;

  modport master (
    output man_req_i, man_dat_i, man_sel_i,
    input  dac_dat_o, dac_sel_o, dac_wrt_o
  );

  modport slave (
    input  man_req_i, man_dat_i, man_sel_i,
    output dac_dat_o, dac_sel_o, dac_wrt_o
  );
endinterface

// File: rtl/ramp_dwell_timer.sv
// Loadable down-counter pacing sweep updates.
//   load     : reload with load_val (takes priority)
//   hold     : freeze the count
//   expire   : count has reached zero; stays there until reloaded
module ramp_dwell_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         hold,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                         cnt_q <= '0;
    else if (load)                   cnt_q <= load_val;
    else if (!hold && cnt_q != '0)   cnt_q <= cnt_q - W'(1);
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/dac_ramp_sequencer.sv
// Triangle sweep generator for one DAC channel plus arbitration of the shared
// DAC write port against manual writes (manual always wins).
//   clk, rst            : clock, synchronous active-high reset
//   cfg_*_i             : sweep config, shadowed on an accepted start
//   start_i / stop_i    : single-cycle control pulses
//   bus (slave)         : manual write in, registered DAC drive out
//   busy_o              : sweep running or parking
//   dir_o               : 0 rising, 1 falling
//   sweep_cnt_o         : completed triangle periods since last start
//   cfg_err_o           : last start was rejected
module dac_ramp_sequencer #(
  parameter int DAC_DATA_WIDTH = pdh_pkg::DAC_DATA_WIDTH,
  parameter int DWELL_WIDTH    = 16,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DAC_DATA_WIDTH-1:0] cfg_min_i,
  input  logic [DAC_DATA_WIDTH-1:0] cfg_max_i,
  input  logic [DAC_DATA_WIDTH-1:0] cfg_step_i,
  input  logic [DWELL_WIDTH-1:0]    cfg_dwell_i,
  input  logic                      cfg_sel_i,
  input  logic                      start_i,
  input  logic                      stop_i,
  dac_ramp_sequencer_if.slave       bus,
  output logic                      busy_o,
  output logic                      dir_o,
  output logic [CNT_WIDTH-1:0]      sweep_cnt_o,
  output logic                      cfg_err_o
);
  import pdh_pkg::*;

  localparam int W = DAC_DATA_WIDTH;
  localparam logic [W-1:0] MIDSCALE = W'(DAC_MIDSCALE);

  localparam logic [1:0] ST_IDLE = RAMP_IDLE;
  localparam logic [1:0] ST_UP   = RAMP_UP;
  localparam logic [1:0] ST_DOWN = RAMP_DOWN;
  localparam logic [1:0] ST_PARK = RAMP_PARK;

  // shadow config
  logic [W-1:0]           min_q, max_q, step_q;
  logic [DWELL_WIDTH-1:0] dwell_q;
  logic                   sel_q;

  logic [1:0]           state_q, state_d;
  logic [W-1:0]         value_q, value_d;
  logic                 dir_q, dir_d;
  logic                 err_q, err_d;
  logic                 pend_q, pend_d;   // start write lost to a manual strobe
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [W-1:0] dat_q;
  logic         wsel_q, wrt_q;

  logic                   latch;
  logic                   swp_wr;
  logic [W-1:0]           swp_dat;
  logic                   swp_sel;
  logic                   tmr_load, tmr_hold, tmr_expire;
  logic [DWELL_WIDTH-1:0] tmr_val;

  logic                 man;
  logic                 cfg_ok;
  logic [W:0]           up_sum;
  logic signed [W:0]    dn_diff;
  logic                 up_hit, dn_hit;

  assign man    = bus.man_req_i;
  assign cfg_ok = (cfg_min_i < cfg_max_i) && (cfg_step_i != '0);

  // one extra bit so max+step never wraps and min-step can go negative
  assign up_sum  = {1'b0, value_q} + {1'b0, step_q};
  assign dn_diff = $signed({1'b0, value_q}) - $signed({1'b0, step_q});
  assign up_hit  = up_sum >= {1'b0, max_q};
  assign dn_hit  = dn_diff <= $signed({1'b0, min_q});

  ramp_dwell_timer #(.W(DWELL_WIDTH)) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .hold     (tmr_hold),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    dir_d    = dir_q;
    err_d    = err_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    latch    = 1'b0;
    swp_wr   = 1'b0;
    swp_dat  = value_q;
    swp_sel  = sel_q;
    tmr_load = 1'b0;
    tmr_hold = 1'b0;
    tmr_val  = dwell_q;

    case (state_q)
      ST_IDLE: begin
        // start together with stop is dropped here
        if (start_i && !stop_i) begin
          if (!cfg_ok) begin
            err_d = 1'b1;
          end else begin
            err_d    = 1'b0;
            latch    = 1'b1;
            value_d  = cfg_min_i;
            state_d  = ST_UP;
            dir_d    = 1'b0;
            cnt_d    = '0;
            swp_dat  = cfg_min_i;
            swp_sel  = cfg_sel_i;
            tmr_load = 1'b1;
            if (man) begin
              // park the timer at zero; the min write goes out on the first free cycle
              pend_d  = 1'b1;
              tmr_val = '0;
            end else begin
              pend_d  = 1'b0;
              swp_wr  = 1'b1;
              tmr_val = cfg_dwell_i;
            end
          end
        end
      end

      ST_UP, ST_DOWN: begin
        if (stop_i) begin
          state_d = ST_PARK;
          pend_d  = 1'b0;
        end else if (pend_q) begin
          if (man) begin
            tmr_hold = 1'b1;
          end else begin
            swp_wr   = 1'b1;
            pend_d   = 1'b0;
            tmr_load = 1'b1;
          end
        end else if (tmr_expire) begin
          if (man) begin
            // nothing commits, so the same update is recomputed next cycle
            tmr_hold = 1'b1;
          end else begin
            swp_wr   = 1'b1;
            tmr_load = 1'b1;
            if (state_q == ST_UP) begin
              if (up_hit) begin
                value_d = max_q;
                state_d = ST_DOWN;
                dir_d   = 1'b1;
              end else begin
                value_d = up_sum[W-1:0];
              end
            end else begin
              if (dn_hit) begin
                value_d = min_q;
                state_d = ST_UP;
                dir_d   = 1'b0;
                cnt_d   = cnt_q + CNT_WIDTH'(1);
              end else begin
                value_d = dn_diff[W-1:0];
              end
            end
            swp_dat = value_d;
          end
        end
      end

      ST_PARK: begin
        swp_dat = min_q;
        if (!man) begin
          swp_wr  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      value_q <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      min_q   <= '0;
      max_q   <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        min_q   <= cfg_min_i;
        max_q   <= cfg_max_i;
        step_q  <= cfg_step_i;
        dwell_q <= cfg_dwell_i;
        sel_q   <= cfg_sel_i;
      end
    end
  end

  // output register: manual strobe always owns the port
  always_ff @(posedge clk) begin
    if (rst) begin
      dat_q  <= MIDSCALE;
      wsel_q <= 1'b0;
      wrt_q  <= 1'b0;
    end else if (man) begin
      dat_q  <= bus.man_dat_i;
      wsel_q <= bus.man_sel_i;
      wrt_q  <= 1'b1;
    end else if (swp_wr) begin
      dat_q  <= swp_dat;
      wsel_q <= swp_sel;
      wrt_q  <= 1'b1;
    end else begin
      wrt_q  <= 1'b0;
    end
  end

  assign bus.dac_dat_o = dat_q;
  assign bus.dac_sel_o = wsel_q;
  assign bus.dac_wrt_o = wrt_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign dir_o         = dir_q;
  assign sweep_cnt_o   = cnt_q;
  assign cfg_err_o     = err_q;

endmodule

// File: tb/tb_dac_ramp_sequencer.sv
// Scoreboard bench for dac_ramp_sequencer: each scenario predicts the full
// DAC write stream (code, channel, cycle) from the triangle rules and the
// manual-priority rule, queues it, and a negedge monitor compares every
// dac_wrt_o pulse against the queue head.
module tb_dac_ramp_sequencer;
  localparam int W  = 14;
  localparam int DW = 16;
  localparam int CW = 16;

  typedef struct {
    int           cyc;
    logic [W-1:0] dat;
    logic         sel;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0]  cfg_min, cfg_max, cfg_step;
  logic [DW-1:0] cfg_dwell;
  logic          cfg_sel, start, stop;
  logic          busy, dir, err;
  logic [CW-1:0] scnt;

  dac_ramp_sequencer_if #(.W(W)) bus ();

  dac_ramp_sequencer #(.DAC_DATA_WIDTH(W), .DWELL_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_min_i   (cfg_min),
    .cfg_max_i   (cfg_max),
    .cfg_step_i  (cfg_step),
    .cfg_dwell_i (cfg_dwell),
    .cfg_sel_i   (cfg_sel),
    .start_i     (start),
    .stop_i      (stop),
    .bus         (bus),
    .busy_o      (busy),
    .dir_o       (dir),
    .sweep_cnt_o (scnt),
    .cfg_err_o   (err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  vectors = 0;
  int  miscompares = 0;
  wr_t exp_q[$];
  logic [W:0] man_tab[int];   // offset -> {sel, dat}
  int  exp_cnt, exp_dir;

  // monitor
  always @(negedge clk) begin
    if (bus.dac_wrt_o === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write cyc=%0d got dat=%h sel=%b, required no write",
                 cyc, bus.dac_dat_o, bus.dac_sel_o);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.dat !== bus.dac_dat_o || e.sel !== bus.dac_sel_o) begin
          miscompares++;
          $display("FAIL dac_write got cyc=%0d dat=%h sel=%b required cyc=%0d dat=%h sel=%b",
                   cyc, bus.dac_dat_o, bus.dac_sel_o, e.cyc, e.dat, e.sel);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0;
    stop  = 1'b0;
    bus.man_req_i = 1'b0;
  endtask

  // Wait (bounded) until every predicted write has been seen, then check status.
  task automatic drain_and_check(input string tag);
    idle_inputs();
    for (int k = 0; k < 2000 && exp_q.size() != 0; k++) tick();
    repeat (4) tick();
    chk({tag, "_leftover"}, exp_q.size(), 0);
    exp_q.delete();
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cnt"},  scnt, exp_cnt);
    chk({tag, "_dir"},  dir,  exp_dir);
    chk({tag, "_err"},  err,  0);
  endtask

  // One sweep scenario. Offsets are in cycles from task entry; an input driven
  // at offset i is sampled at the following edge. stop_off / rst_off < 0 = unused.
  task automatic run_sweep(input string tag, input int mn, input int mx, input int st,
                           input int dw, input logic sl, input int s_off,
                           input int stop_off, input int rst_off, input int ign_off,
                           input bit both, input bit scramble, input int len);
    int  base, limit, v, dr, cnt, due, p;
    bit  first;
    wr_t plan[int];
    base  = cyc;
    limit = (stop_off >= 0) ? base + stop_off : base + rst_off;
    foreach (man_tab[o]) plan[base + o + 1] = '{base + o + 1, man_tab[o][W-1:0], man_tab[o][W]};
    // triangle: rise by step clamped at max, fall by step clamped at min
    v = mn; dr = 0; cnt = 0; due = base + s_off; first = 1'b1;
    while (1) begin
      while (man_tab.exists(due - base)) due++;
      if (due >= limit) break;
      if (!first) begin
        if (dr == 0) begin
          v = v + st;
          if (v >= mx) begin v = mx; dr = 1; end
        end else begin
          v = v - st;
          if (v <= mn) begin v = mn; dr = 0; cnt++; end
        end
      end
      first = 1'b0;
      plan[due + 1] = '{due + 1, W'(v), sl};
      due += dw + 1;
    end
    if (stop_off >= 0) begin
      p = base + stop_off + 1;
      while (man_tab.exists(p - base)) p++;
      plan[p + 1] = '{p + 1, W'(mn), sl};
      exp_cnt = cnt;
      exp_dir = dr;
    end else begin
      exp_cnt = 0;
      exp_dir = 0;
    end
    foreach (plan[k]) exp_q.push_back(plan[k]);

    cfg_min = W'(mn); cfg_max = W'(mx); cfg_step = W'(st); cfg_dwell = DW'(dw); cfg_sel = sl;
    for (int i = 0; i < len; i++) begin
      start = (i == s_off) || (i == ign_off) || (both && i == stop_off);
      stop  = (i == stop_off);
      rst   = (i == rst_off);
      if (man_tab.exists(i)) begin
        bus.man_req_i = 1'b1;
        bus.man_dat_i = man_tab[i][W-1:0];
        bus.man_sel_i = man_tab[i][W];
      end else begin
        bus.man_req_i = 1'b0;
        bus.man_dat_i = W'($urandom);
        bus.man_sel_i = 1'($urandom);
      end
      if (scramble && i > s_off) begin
        cfg_min = W'($urandom); cfg_max = W'($urandom); cfg_step = W'($urandom);
        cfg_dwell = DW'($urandom); cfg_sel = 1'($urandom);
      end
      if (i == s_off + 1) chk({tag, "_busy_run"}, busy, 1);
      if (rst_off >= 0 && i == rst_off) chk({tag, "_cnt_pre_rst"}, scnt, cnt);
      if (rst_off >= 0 && i == rst_off + 1) begin
        chk({tag, "_rst_dat"},  bus.dac_dat_o, 14'h2000);
        chk({tag, "_rst_wrt"},  bus.dac_wrt_o, 0);
        chk({tag, "_rst_busy"}, busy, 0);
        chk({tag, "_rst_cnt"},  scnt, 0);
      end
      tick();
    end
    rst = 1'b0;
    drain_and_check(tag);
    man_tab.delete();
  endtask

  task automatic run_reject(input string tag, input int mn, input int mx, input int st);
    cfg_min = W'(mn); cfg_max = W'(mx); cfg_step = W'(st); cfg_dwell = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_err"},  err,  1);
    chk({tag, "_busy"}, busy, 0);
    repeat (6) tick();
    chk({tag, "_busy_late"}, busy, 0);
    chk({tag, "_err_hold"},  err,  1);
  endtask

  initial begin
    int mn, mx, st, dw, s_off, stop_off, len, ign;
    cfg_min = '0; cfg_max = '0; cfg_step = '0; cfg_dwell = '0; cfg_sel = 1'b0;
    bus.man_dat_i = '0; bus.man_sel_i = 1'b0;
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_dat",  bus.dac_dat_o, 14'h2000);
    chk("reset_sel",  bus.dac_sel_o, 0);
    chk("reset_wrt",  bus.dac_wrt_o, 0);
    chk("reset_busy", busy, 0);
    chk("reset_dir",  dir,  0);
    chk("reset_cnt",  scnt, 0);
    chk("reset_err",  err,  0);
    rst = 1'b0;
    tick();

    // basic: 100,200,300,400,300,200,100 every 3 cycles
    run_sweep("basic", 100, 400, 100, 2, 1'b0, 2, 22, -1, -1, 1'b0, 1'b0, 30);
    // clamp at full scale with a large step
    run_sweep("clamp", 0, 16383, 10000, 0, 1'b1, 1, 6, -1, -1, 1'b0, 1'b0, 12);

    run_reject("rej_eq", 500, 500, 10);
    run_reject("rej_step0", 100, 400, 0);

    // manual write on the first sweep update, plus an ignored start mid-sweep
    man_tab[5] = {1'b1, 14'h1234};
    run_sweep("collide", 100, 400, 100, 2, 1'b0, 2, 22, -1, 9, 1'b0, 1'b1, 30);

    // manual write in the start cycle itself
    man_tab[3] = {1'b0, 14'h0abc};
    man_tab[4] = {1'b1, 14'h0def};
    run_sweep("start_col", 50, 90, 20, 1, 1'b1, 3, 15, -1, -1, 1'b0, 1'b0, 22);

    // start and stop together while running
    run_sweep("startstop", 100, 400, 100, 1, 1'b1, 1, 10, -1, -1, 1'b1, 1'b0, 16);

    // step wider than the span
    run_sweep("bigstep", 1000, 1010, 50, 0, 1'b0, 1, 8, -1, -1, 1'b0, 1'b0, 14);

    // reset mid-sweep after a completed period: no park write
    run_sweep("rst_mid", 100, 300, 100, 0, 1'b1, 1, -1, 11, -1, 1'b0, 1'b0, 16);

    for (int n = 0; n < 25; n++) begin
      mn = $urandom_range(0, 16000);
      mx = mn + $urandom_range(1, 300);
      if (mx > 16383) mx = 16383;
      st = $urandom_range(1, (mx - mn) + 40);
      dw = $urandom_range(0, 3);
      s_off = $urandom_range(1, 4);
      stop_off = s_off + $urandom_range(2, 60);
      len = stop_off + 8;
      ign = (n % 3 == 0) ? s_off + $urandom_range(1, stop_off - s_off) : -1;
      for (int i = 0; i < len; i++)
        if ($urandom_range(0, 5) == 0) man_tab[i] = (W+1)'($urandom);
      run_sweep("rand", mn, mx, st, dw, 1'($urandom), s_off, stop_off, -1, ign,
                1'($urandom_range(0, 3) == 0), 1'b1, len);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dac_ramp_sequencer.md
# dac_ramp_sequencer

Drives one DAC channel with a programmable triangle sweep (min → max → min) so the cavity or laser can be scanned before locking. It also arbitrates the shared DAC write port between the sweep and single-shot manual writes from the PS command decoder. It sits between the command/register logic in `pdh_core` and the DAC pins (`dac_dat_o`/`dac_sel_o`/`dac_wrt_o`).

## Interface
- `DAC_DATA_WIDTH`, 14, DAC code width
- `DWELL_WIDTH`, 16, dwell counter width
- `CNT_WIDTH`, 16, sweep period counter width

Ports:
- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  reset, synchronous, active-high
- `cfg_min_i`  in  14  sweep lower bound (unsigned code)
- `cfg_max_i`  in  14  sweep upper bound
- `cfg_step_i`  in  14  code increment per update
- `cfg_dwell_i`  in  16  extra cycles between sweep updates
- `cfg_sel_i`  in  1  DAC channel for the sweep
- `start_i`  in  1  single-cycle start pulse
- `stop_i`  in  1  single-cycle stop pulse
- `man_req_i`  in  1  single-cycle manual write strobe
- `man_dat_i`  in  14  manual write code
- `man_sel_i`  in  1  manual write channel
- `dac_dat_o`  out  14  DAC code, registered
- `dac_sel_o`  out  1  DAC channel select, registered
- `dac_wrt_o`  out  1  one-cycle write pulse, registered
- `busy_o`  out  1  high in UP/DOWN/PARK
- `dir_o`  out  1  0 = rising, 1 = falling
- `sweep_cnt_o`  out  16  completed triangle periods
- `cfg_err_o`  out  1  last start rejected

## Operation
- States: IDLE, UP, DOWN, PARK.
- **IDLE, start_i accepted:** min/max/step/dwell/sel are latched into shadow registers, so later config changes do not affect a running sweep.
  - Validation: if `cfg_min_i >= cfg_max_i` or `cfg_step_i == 0`, set `cfg_err_o` = 1 and stay in IDLE.
  - Otherwise clear `cfg_err_o`, set value = min, schedule a write, go to UP, clear `sweep_cnt_o`.
- **UP:** when the dwell timer expires, next = value + step, computed in 15 bits.
  - If next ≥ max: value = max, go to DOWN, set `dir_o` = 1.
  - Otherwise value = next.
  - Each update schedules a write and reloads the timer.
- **DOWN:** next = value − step, computed signed in 15 bits.
  - If next ≤ min: value = min, go to UP, set `dir_o` = 0, increment `sweep_cnt_o` (wraps at 2^16).
- **stop_i in UP/DOWN:** go to PARK. PARK issues one write of the shadow min on the shadow channel, then returns to IDLE.
- Ignored events:
  - `start_i` outside IDLE.
  - `stop_i` in IDLE or PARK.
  - If `start_i` and `stop_i` arrive in the same cycle, `stop_i` wins (in IDLE both are ignored).
- **Arbitration:** `man_req_i` always wins.
  - In its cycle the output register loads `man_dat_i`/`man_sel_i` and `dac_wrt_o` pulses.
  - A colliding sweep or PARK write is held pending (timer frozen at zero) and issued in the first cycle without `man_req_i`.
  - Continuous manual strobes starve the sweep. This is intended.
  - Manual writes are accepted in every state.
- A step larger than the span is legal: writes alternate min, max, min.

## Timing
- Reset values:
  - `dac_dat_o` = 14'h2000 (midscale, ~0 V)
  - `dac_sel_o` = 0, `dac_wrt_o` = 0, `busy_o` = 0, `dir_o` = 0
  - `sweep_cnt_o` = 0, `cfg_err_o` = 0
  - State = IDLE
- Reset mid-sweep aborts on the next edge. No PARK write is issued.
- Start latency: `start_i` sampled at cycle N gives `dac_wrt_o` = 1 with the min code at N+1.
- Without collisions, sweep writes occur at N+1+k·(dwell+1). With dwell = 0 the sweep writes every cycle.
- Each collision delays that write and all later writes by 1 cycle.
- Manual write latency: 1 cycle from `man_req_i` to `dac_wrt_o`.
- `dac_dat_o`/`dac_sel_o` hold their last written value between pulses.
- `cfg_err_o` is set 1 cycle after the rejected start.
- `busy_o` rises 1 cycle after an accepted start and falls the cycle after the PARK write.

## Structure
- Shared package `pdh_pkg` holds:
  - the `ramp_state_t` enum (IDLE, UP, DOWN, PARK)
  - `DAC_MIDSCALE` = 14'h2000
  - `DAC_DATA_WIDTH`
- Sub-module `ramp_dwell_timer`: a loadable down-counter with `load`, `hold` and `expire` signals, used for the dwell timing and collision freeze.
- Everything else lives in one FSM plus the output register.

## Test plan
- **Basic sweep:** min = 100, max = 400, step = 100, dwell = 2 → writes 100, 200, 300, 400, 300, 200, 100, spaced 3 cycles apart, with the first write 1 cycle after start. `sweep_cnt_o` = 1 after the final 100.
- **Clamp:** min = 0, max = 16383, step = 10000, dwell = 0 → writes 0, 10000, 16383, 6383, 0 with no 15-bit overflow.
- **Config rejects:**
  - min = 500, max = 500 → `cfg_err_o` = 1, no write, `busy_o` = 0.
  - step = 0 → same result.
  - A following valid start clears `cfg_err_o`.
- **Manual collision:** `man_req_i` (code 0x1234, sel = 1) lands in the same cycle as a sweep update → manual write first, sweep write 1 cycle later, and the timing of all later writes shifts by 1.
- **Stop and park:**
  - `stop_i` mid-DOWN → one write of the min code, then IDLE.
  - `start_i` + `stop_i` in the same cycle while running → park.
  - `start_i` during a sweep → ignored.
- **Reset mid-sweep:** assert `rst` → next cycle `dac_dat_o` = 0x2000, `dac_wrt_o` = 0, `busy_o` = 0, `sweep_cnt_o` = 0, and no PARK write.
